// File: rtl/ahb_bus_arbiter.sv
// AHB bus arbiter: round-robin grant with fixed-length burst hold and default-master parking.
// Optional bus locking (hlock/hmastlock) is enabled by defining AHB_ARB_LOCK_EN.
module ahb_bus_arbiter #(
  parameter int MASTER_NUM     = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MI_W           = $clog2(MASTER_NUM)
) (
  input  logic                  hclk,
  input  logic                  hreset_n,
  input  logic [MASTER_NUM-1:0] hbusreq,
`ifdef AHB_ARB_LOCK_EN
  input  logic [MASTER_NUM-1:0] hlock,
`endif
  input  logic [1:0]            htrans,
  input  logic [2:0]            hburst,
  input  logic                  hready,
  output logic [MASTER_NUM-1:0] hgrant,
  output logic [MI_W-1:0]       hmaster,
  output logic                  hmastlock
);

  localparam logic [1:0] TR_IDLE   = 2'd0;
  localparam logic [1:0] TR_NONSEQ = 2'd2;
  localparam logic [1:0] TR_SEQ    = 2'd3;

  localparam logic [2:0] HB_WRAP4  = 3'd2;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_WRAP8  = 3'd4;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_WRAP16 = 3'd6;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  localparam logic [MI_W-1:0] DEF_IDX = MI_W'(DEFAULT_MASTER);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  state_e                state_r;
  logic [3:0]            beat_cnt_r;
  logic [MI_W-1:0]       rr_ptr_r;
  logic [MI_W-1:0]       gidx_r;
  logic [MASTER_NUM-1:0] hgrant_r;
  logic [MI_W-1:0]       hmaster_r;
  logic                  hmastlock_r;
  logic                  lock_tail_r;

  logic                  fixed_s;
  logic [3:0]            beats_s;
  logic                  in_burst_s;
  logic                  last_beat_s;
  logic                  early_term_s;
  logic                  burst_start_s;
  logic                  arb_pt_s;
  logic                  found_s;
  logic [MI_W-1:0]       winner_s;
  logic [MI_W-1:0]       cand_s;
  logic [MI_W-1:0]       next_gidx_s;
  logic [MI_W-1:0]       next_rr_s;
  logic                  owner_lock_s;
  logic                  lock_hold_s;

  function automatic logic [MI_W-1:0] wrap_idx(input logic [MI_W-1:0] base, input int off);
    int sum;
    sum = (int'(base) + off) % MASTER_NUM;
    return MI_W'(sum);
  endfunction

`ifdef AHB_ARB_LOCK_EN
  assign owner_lock_s = hlock[gidx_r];
`else
  assign owner_lock_s = 1'b0;
`endif

  // Lock keeps the grant while asserted and for one arbitration point after it drops
  assign lock_hold_s = owner_lock_s | lock_tail_r;

  // Decode fixed-length burst types into the counter preload (beats minus two)
  always_comb begin
    fixed_s = 1'b1;
    beats_s = 4'd0;
    case (hburst)
      HB_INCR4, HB_WRAP4:   beats_s = 4'd2;
      HB_INCR8, HB_WRAP8:   beats_s = 4'd6;
      HB_INCR16, HB_WRAP16: beats_s = 4'd14;
      default:              fixed_s = 1'b0;
    endcase
  end

  // Classify the current cycle: burst end, early termination, burst start, arbitration point
  always_comb begin
    in_burst_s    = (state_r == ST_BURST);
    last_beat_s   = in_burst_s && (htrans == TR_SEQ) && (beat_cnt_r == 4'd0);
    early_term_s  = in_burst_s && ((htrans == TR_IDLE) || (htrans == TR_NONSEQ));
    // A fixed burst being opened keeps its owner, so it is not re-arbitrated
    burst_start_s = (!in_burst_s || early_term_s) && (htrans == TR_NONSEQ) && fixed_s;
    arb_pt_s      = hready && (!in_burst_s || last_beat_s || early_term_s) && !burst_start_s;
  end

  // Round-robin search starting one past the last winner
  always_comb begin
    found_s  = 1'b0;
    winner_s = DEF_IDX;
    cand_s   = DEF_IDX;
    for (int i = 1; i <= MASTER_NUM; i++) begin
      cand_s = wrap_idx(rr_ptr_r, i);
      if (!found_s && hbusreq[cand_s]) begin
        found_s  = 1'b1;
        winner_s = cand_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Next grant index and round-robin pointer
  always_comb begin
    next_gidx_s = gidx_r;
    next_rr_s   = rr_ptr_r;
    if (arb_pt_s && !lock_hold_s) begin
      if (found_s) begin
        next_gidx_s = winner_s;
        if (winner_s != gidx_r) begin
          next_rr_s = winner_s;
        end else begin
          next_rr_s = rr_ptr_r;
        end
      end else begin
        next_gidx_s = DEF_IDX;
      end
    end else begin
      next_gidx_s = gidx_r;
    end
  end

  // Burst FSM, grant, owner and lock registers; everything holds while hready is low
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_r     <= ST_ARB;
      beat_cnt_r  <= 4'd0;
      rr_ptr_r    <= DEF_IDX;
      gidx_r      <= DEF_IDX;
      hgrant_r    <= MASTER_NUM'(1) << DEF_IDX;
      hmaster_r   <= DEF_IDX;
      hmastlock_r <= 1'b0;
      lock_tail_r <= 1'b0;
    end else if (hready) begin
      hmaster_r   <= gidx_r;
      hmastlock_r <= owner_lock_s;
      gidx_r      <= next_gidx_s;
      hgrant_r    <= MASTER_NUM'(1) << next_gidx_s;
      rr_ptr_r    <= next_rr_s;
      if (arb_pt_s) begin
        lock_tail_r <= owner_lock_s;
      end else begin
        lock_tail_r <= lock_tail_r;
      end
      case (state_r)
        ST_ARB: begin
          if (burst_start_s) begin
            state_r    <= ST_BURST;
            beat_cnt_r <= beats_s;
          end else begin
            state_r    <= ST_ARB;
          end
        end
        ST_BURST: begin
          if (burst_start_s) begin
            beat_cnt_r <= beats_s;
          end else if (last_beat_s || early_term_s) begin
            state_r    <= ST_ARB;
            beat_cnt_r <= 4'd0;
          end else if (htrans == TR_SEQ) begin
            beat_cnt_r <= beat_cnt_r - 4'd1;
          end else begin
            beat_cnt_r <= beat_cnt_r;
          end
        end
        default: begin
          state_r    <= ST_ARB;
          beat_cnt_r <= 4'd0;
        end
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  assign hgrant    = hgrant_r;
  assign hmaster   = hmaster_r;
  assign hmastlock = hmastlock_r;

endmodule

// File: tb/tb_ahb_bus_arbiter.sv
// Directed self-checking bench for ahb_bus_arbiter (4 masters, default master 0).
// The lock scenario is compiled only when AHB_ARB_LOCK_EN is defined.
module tb_ahb_bus_arbiter;

  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NONSEQ = 2'd2, SEQ = 2'd3;
  localparam logic [2:0] SINGLE = 3'd0, INCR = 3'd1, INCR4 = 3'd3, INCR8 = 3'd5, WRAP16 = 3'd6;

  logic       hclk;
  logic       hreset_n;
  logic [3:0] hbusreq;
  logic [1:0] htrans;
  logic [2:0] hburst;
  logic       hready;
  logic [3:0] hgrant;
  logic [1:0] hmaster;
  logic       hmastlock;
`ifdef AHB_ARB_LOCK_EN
  logic [3:0] hlock;
`endif

  int checks = 0;
  int errors = 0;

  ahb_bus_arbiter #(.MASTER_NUM(4), .DEFAULT_MASTER(0)) dut (
    .hclk      (hclk),
    .hreset_n  (hreset_n),
    .hbusreq   (hbusreq),
`ifdef AHB_ARB_LOCK_EN
    .hlock     (hlock),
`endif
    .htrans    (htrans),
    .hburst    (hburst),
    .hready    (hready),
    .hgrant    (hgrant),
    .hmaster   (hmaster),
    .hmastlock (hmastlock)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [1:0] tr, input logic [2:0] hb, input logic rdy);
    hbusreq = req;
    htrans  = tr;
    hburst  = hb;
    hready  = rdy;
  endtask

  initial begin
    hreset_n = 1'b1;
    drive(4'b0000, IDLE, SINGLE, 1'b1);
`ifdef AHB_ARB_LOCK_EN
    hlock = 4'b0000;
`endif
    #2 hreset_n = 1'b0;
    #1;
    check("rst_grant", 32'(hgrant), 32'h1);
    check("rst_master", 32'(hmaster), 32'h0);
    check("rst_mastlock", 32'(hmastlock), 32'h0);
    step();
    step();
    hreset_n = 1'b1;

    // Idle parking on the default master
    for (int i = 0; i < 10; i++) begin
      step();
      check("park_grant", 32'(hgrant), 32'h1);
    end
    check("park_master", 32'(hmaster), 32'h0);

    // Round robin among four requesters with SINGLE transfers
    drive(4'b1111, NONSEQ, SINGLE, 1'b1);
    step(); check("rr_g1", 32'(hgrant), 32'h2); check("rr_m1", 32'(hmaster), 32'h0);
    step(); check("rr_g2", 32'(hgrant), 32'h4); check("rr_m2", 32'(hmaster), 32'h1);
    step(); check("rr_g3", 32'(hgrant), 32'h8); check("rr_m3", 32'(hmaster), 32'h2);
    step(); check("rr_g4", 32'(hgrant), 32'h1); check("rr_m4", 32'(hmaster), 32'h3);

    // INCR8 from M1 with M2 requesting, two BUSY cycles, M1 drops its request mid-burst
    drive(4'b0110, IDLE, SINGLE, 1'b1);
    step(); check("b8_grant_m1", 32'(hgrant), 32'h2);
    drive(4'b0110, NONSEQ, INCR8, 1'b1);
    step(); check("b8_nonseq", 32'(hgrant), 32'h2); check("b8_owner", 32'(hmaster), 32'h1);
    drive(4'b0110, SEQ, INCR8, 1'b1);
    step(); check("b8_seq1", 32'(hgrant), 32'h2);
    step(); check("b8_seq2", 32'(hgrant), 32'h2);
    drive(4'b0100, BUSY, INCR8, 1'b1);
    step(); check("b8_busy1", 32'(hgrant), 32'h2);
    step(); check("b8_busy2", 32'(hgrant), 32'h2);
    drive(4'b0100, SEQ, INCR8, 1'b1);
    for (int i = 3; i <= 6; i++) begin
      step(); check("b8_seq_mid", 32'(hgrant), 32'h2);
    end
    step(); check("b8_last_regrant", 32'(hgrant), 32'h4);
    check("b8_last_master", 32'(hmaster), 32'h1);
    drive(4'b0100, IDLE, SINGLE, 1'b1);
    step(); check("m2_sole", 32'(hgrant), 32'h4); check("m2_owner", 32'(hmaster), 32'h2);

    // INCR4 from M2 with wait states, then early IDLE termination
    drive(4'b1100, NONSEQ, INCR4, 1'b1);
    step(); check("b4_nonseq", 32'(hgrant), 32'h4);
    drive(4'b1100, SEQ, INCR4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("ws_grant", 32'(hgrant), 32'h4);
      check("ws_master", 32'(hmaster), 32'h2);
      check("ws_mastlock", 32'(hmastlock), 32'h0);
    end
    drive(4'b1100, SEQ, INCR4, 1'b1);
    step(); check("b4_beat2", 32'(hgrant), 32'h4);
    drive(4'b1100, IDLE, SINGLE, 1'b1);
    step(); check("early_term_regrant", 32'(hgrant), 32'h8);
    check("early_term_master", 32'(hmaster), 32'h2);

    // WRAP16 from M3 interrupted by reset during beat 5
    drive(4'b1000, NONSEQ, WRAP16, 1'b1);
    step(); check("w16_nonseq", 32'(hmaster), 32'h3);
    drive(4'b1000, SEQ, WRAP16, 1'b1);
    step(); step(); step();
    check("w16_beat4", 32'(hgrant), 32'h8);
    #2 hreset_n = 1'b0;
    #1;
    check("midrst_grant", 32'(hgrant), 32'h1);
    check("midrst_master", 32'(hmaster), 32'h0);
    step();
    hreset_n = 1'b1;

    // New INCR4 from M3 after reset, M0 waiting
    drive(4'b1000, IDLE, SINGLE, 1'b1);
    step(); check("post_rst_grant_m3", 32'(hgrant), 32'h8);
    drive(4'b1001, NONSEQ, INCR4, 1'b1);
    step(); check("post_b4_nonseq", 32'(hgrant), 32'h8); check("post_b4_owner", 32'(hmaster), 32'h3);
    drive(4'b1001, SEQ, INCR4, 1'b1);
    step(); check("post_b4_seq1", 32'(hgrant), 32'h8);
    step(); check("post_b4_seq2", 32'(hgrant), 32'h8);
    step(); check("post_b4_done", 32'(hgrant), 32'h1);
    check("post_b4_master", 32'(hmaster), 32'h3);

`ifdef AHB_ARB_LOCK_EN
    // M2 locked over three INCR transfers while M0 keeps requesting
    drive(4'b0101, IDLE, SINGLE, 1'b1);
    hlock = 4'b0100;
    step(); check("lk_grant_m2", 32'(hgrant), 32'h4);
    drive(4'b0101, NONSEQ, INCR, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("lk_hold", 32'(hgrant), 32'h4);
      check("lk_master", 32'(hmaster), 32'h2);
      check("lk_mastlock", 32'(hmastlock), 32'h1);
    end
    hlock = 4'b0000;
    step(); check("lk_tail_hold", 32'(hgrant), 32'h4);
    check("lk_tail_mastlock", 32'(hmastlock), 32'h0);
    step(); check("lk_release_m0", 32'(hgrant), 32'h1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
